// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the multi-channel XADC sequencer.
package adc_seq_pkg;

    localparam int XADC_SAMPLE_W = 12;
    localparam logic [6:0] XADC_AUX_BASE = 7'h10;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RDY,
        ACCUM
    } adc_seq_state_t;

endpackage

// File: rtl/adc_channel_accumulator.sv
// Per-channel sample accumulator; publishes the unshifted sum of 2**AVG_LOG2 samples.
module adc_channel_accumulator
    import adc_seq_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              add_en,
    input  logic [XADC_SAMPLE_W-1:0]          sample,
    output logic [XADC_SAMPLE_W+AVG_LOG2-1:0] ave_out,
    output logic                              done
);

    localparam int W  = XADC_SAMPLE_W + AVG_LOG2;
    localparam int CW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] LAST = CW'((1 << AVG_LOG2) - 1);

    logic [W-1:0]  acc;
    logic [CW-1:0] cnt;
    logic [W-1:0]  sum;

    // Accumulator is wide enough for 2**AVG_LOG2 full-scale samples.
    assign sum  = acc + W'(sample);
    assign done = add_en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            cnt     <= '0;
            ave_out <= '0;
        end else if (add_en) begin
            if (done) begin
                ave_out <= sum;
                acc     <= '0;
                cnt     <= '0;
            end else begin
                acc <= sum;
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/adc_channel_sequencer.sv
// Round-robin XADC DRP sequencer with per-channel averaging.
// Optional DRP timeout enabled by defining ADC_SEQ_TIMEOUT_EN.
module adc_channel_sequencer
    import adc_seq_pkg::*;
#(
    parameter int         NUM_CH       = 4,
    parameter logic [6:0] CH_ADDR_BASE = 7'h1C,
    parameter int         AVG_LOG2     = 4,
    parameter int         TIMEOUT      = 255
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     eoc_in,
    input  logic                                     drdy_in,
    input  logic [15:0]                              do_in,
    output logic                                     den_out,
    output logic [6:0]                               daddr_out,
    input  logic [2:0]                               sel_ch,
    output logic [NUM_CH*(XADC_SAMPLE_W+AVG_LOG2)-1:0] ave_bus,
    output logic [XADC_SAMPLE_W+AVG_LOG2-1:0]        sel_data,
    output logic                                     ave_valid,
    output logic [2:0]                               ave_ch,
    output logic                                     drp_err
);

    localparam int W = XADC_SAMPLE_W + AVG_LOG2;

    adc_seq_state_t state, state_nxt;

    logic [2:0]               cur_ch;
    logic [2:0]               ch_nxt;
    logic [XADC_SAMPLE_W-1:0] sample;
    logic                     timeout;
    logic [NUM_CH-1:0]        add_en;
    logic [NUM_CH-1:0]        done;
    logic [W-1:0]             ave_w [NUM_CH];
    logic [W-1:0]             sel_nxt;
    logic                     unused_lsb;

    assign unused_lsb = ^do_in[3:0];

`ifdef ADC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt <= '0;
        end else if (state == WAIT_RDY && !drdy_in) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    assign timeout = (state == WAIT_RDY) && !drdy_in &&
                     (tmo_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            drp_err <= 1'b0;
        end else if (timeout) begin
            drp_err <= 1'b1;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT;

    assign timeout = 1'b0;
    assign drp_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (eoc_in) state_nxt = REQ;
            REQ:      state_nxt = WAIT_RDY;
            WAIT_RDY: begin
                if (drdy_in) begin
                    state_nxt = ACCUM;
                end else if (timeout) begin
                    state_nxt = IDLE;
                end
            end
            ACCUM:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Address tracks the pointer, so it is stable for the whole read.
    assign den_out   = (state == REQ);
    assign daddr_out = CH_ADDR_BASE + {4'b0000, cur_ch};
    assign ch_nxt    = (cur_ch == 3'(NUM_CH - 1)) ? 3'd0 : cur_ch + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_ch    <= '0;
            sample    <= '0;
            ave_valid <= 1'b0;
            ave_ch    <= '0;
            sel_data  <= '0;
        end else begin
            ave_valid <= 1'b0;
            sel_data  <= sel_nxt;
            if (state == WAIT_RDY && drdy_in) begin
                sample <= do_in[15:4];
            end
            if (state == ACCUM) begin
                ave_valid <= |done;
                if (|done) begin
                    ave_ch <= cur_ch;
                end
            end
            if (state == ACCUM || timeout) begin
                cur_ch <= ch_nxt;
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign add_en[k] = (state == ACCUM) && (cur_ch == 3'(k));

        adc_channel_accumulator #(
            .AVG_LOG2(AVG_LOG2)
        ) u_acc (
            .clk    (clk),
            .reset  (reset),
            .add_en (add_en[k]),
            .sample (sample),
            .ave_out(ave_w[k]),
            .done   (done[k])
        );

        assign ave_bus[k*W +: W] = ave_w[k];
    end

    // Unpopulated selector codes read as zero.
    always_comb begin
        sel_nxt = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (sel_ch == 3'(k)) begin
                sel_nxt = ave_w[k];
            end
        end
    end

endmodule
